half_adder: RTL and testbench

HALF_ADDER -- requirements
Module: half_adder

---
 rtl/half_adder.sv | 75 +++++++
 tb/tb_half_adder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// half_adder: registered array of WIDTH independent one-bit half adders.
// Each captured operand pair yields sum = a ^ b and carry = a & b, plus
// two summary flags derived from the same operands, one cycle later.
module half_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             carry_any,
  output logic             sum_all_ones
);

  // High when at least one bit position generates a carry.
  function automatic logic any_set(input logic [WIDTH-1:0] v);
    any_set = |v;
  endfunction

  // High when every bit position of the vector is 1.
  function automatic logic all_set(input logic [WIDTH-1:0] v);
    all_set = &v;
  endfunction

  logic [WIDTH-1:0] sum_d, sum_q;
  logic [WIDTH-1:0] carry_d, carry_q;
  logic             carry_any_d, carry_any_q;
  logic             sum_all_ones_d, sum_all_ones_q;
  logic             out_valid_d, out_valid_q;

  // Next state: capture a fresh result on in_valid, otherwise hold; the
  // flags are computed from the same a/b as sum/carry so they never lag.
  always_comb begin
    sum_d          = sum_q;
    carry_d        = carry_q;
    carry_any_d    = carry_any_q;
    sum_all_ones_d = sum_all_ones_q;
    out_valid_d    = in_valid;
    if (in_valid) begin
      sum_d          = a ^ b;
      carry_d        = a & b;
      carry_any_d    = any_set(a & b);
      sum_all_ones_d = all_set(a ^ b);
    end
  end

  // Result registers; reset clears everything at once, dropping any
  // result that was captured but not yet consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q          <= '0;
      carry_q        <= '0;
      carry_any_q    <= 1'b0;
      sum_all_ones_q <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      sum_q          <= sum_d;
      carry_q        <= carry_d;
      carry_any_q    <= carry_any_d;
      sum_all_ones_q <= sum_all_ones_d;
      out_valid_q    <= out_valid_d;
    end
  end

  assign sum          = sum_q;
  assign carry        = carry_q;
  assign carry_any    = carry_any_q;
  assign sum_all_ones = sum_all_ones_q;
  assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: directed and random stimulus against a behavioural
// model of bitwise half addition, compared on every falling clock edge.
module tb_half_adder;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic [W-1:0] sum;
  logic [W-1:0] carry;
  logic         carry_any;
  logic         sum_all_ones;

  half_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .sum(sum), .carry(carry),
    .carry_any(carry_any), .sum_all_ones(sum_all_ones)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per bit position, add the two operand bits as integers; the
  // low digit of that count is the sum bit, the high digit the carry bit.
  function automatic logic [W-1:0] m_sum_of(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = ((int'(x[i]) + int'(y[i])) % 2) == 1;
    return r;
  endfunction

  function automatic logic [W-1:0] m_carry_of(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = ((int'(x[i]) + int'(y[i])) / 2) == 1;
    return r;
  endfunction

  logic [W-1:0] m_sum = '0, m_carry = '0;
  logic         m_cany = 1'b0, m_sall = 1'b0, m_vld = 1'b0;
  logic [W:0]   m_total = '0;

  // Model state follows the visible contract: new result one edge after
  // a valid operand pair, hold otherwise, cleared the instant reset falls.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum <= '0; m_carry <= '0; m_cany <= 1'b0; m_sall <= 1'b0;
      m_vld <= 1'b0; m_total <= '0;
    end else begin
      m_vld <= in_valid;
      if (in_valid) begin
        m_sum   <= m_sum_of(a, b);
        m_carry <= m_carry_of(a, b);
        m_cany  <= (m_carry_of(a, b) != '0);
        m_sall  <= (m_sum_of(a, b) == {W{1'b1}});
        m_total <= {1'b0, a} + {1'b0, b};
      end
    end
  end

  bit rand_phase = 1'b0;
  int n_out = 0;

  // Compare process: every falling edge, all outputs against the model,
  // plus the arithmetic identity on each produced result.
  always @(negedge clk) begin
    logic [W:0] lhs;
    chk("out_valid", out_valid, m_vld);
    chk("sum", sum, m_sum);
    chk("carry", carry, m_carry);
    chk("carry_any", carry_any, m_cany);
    chk("sum_all_ones", sum_all_ones, m_sall);
    if (out_valid === 1'b1) begin
      lhs = {1'b0, sum} + ({1'b0, carry} << 1);
      chk("identity", lhs, m_total);
      if (rand_phase) n_out++;
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    #1;
    in_valid = v; a = x; b = y;
  endtask

  initial begin
    int n_in;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_carry", carry, 32'h0);
    chk("rst_flags", {carry_any, sum_all_ones}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 5 + 3
    drive(1'b1, 32'd5, 32'd3);
    drive(1'b0, 32'd9, 32'd9);
    @(posedge clk); #1;
    chk("lit53_valid_gone", out_valid, 1'b0);
    chk("lit53_sum_held", sum, 32'd6);
    drive(1'b1, 32'd5, 32'd3);
    @(posedge clk); #1;
    chk("lit53_sum", sum, 32'd6);
    chk("lit53_carry", carry, 32'd1);
    chk("lit53_flags", {carry_any, sum_all_ones, out_valid}, 3'b101);

    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
    @(posedge clk); #1;
    chk("litff_sum", sum, 32'hFFFF_FFFE);
    chk("litff_carry", carry, 32'h0000_0001);
    chk("litff_cany", carry_any, 1'b1);

    drive(1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
    @(posedge clk); #1;
    chk("litaa_sum", sum, 32'hFFFF_FFFF);
    chk("litaa_carry", carry, 32'h0);
    chk("litaa_flags", {carry_any, sum_all_ones}, 2'b01);

    // Hold: zero result held while operands toggle without in_valid
    drive(1'b1, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, $urandom, $urandom);
      @(posedge clk); #1;
      chk("hold_sum", sum, 32'h0);
      chk("hold_carry", carry, 32'h0);
      chk("hold_valid", out_valid, 1'b0);
    end

    // Reset mid-cycle after capture
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    #3 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_sum", sum, 32'h0);
    chk("arst_carry", carry, 32'h0);
    chk("arst_ctl", {out_valid, carry_any, sum_all_ones}, 3'b000);
    @(negedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b1; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    chk("post_rst_sum", sum, 32'h0);
    chk("post_rst_carry", carry, 32'h1);
    chk("post_rst_valid", out_valid, 1'b1);
    drive(1'b0, 32'h0, 32'h0);

    // Random back-to-back stream
    @(negedge clk);
    rand_phase = 1'b1;
    n_in = 0;
    for (int i = 0; i < 10000; i++) begin
      drive(1'b1, $urandom, $urandom);
      n_in++;
    end
    drive(1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1 rand_phase = 1'b0;
    chk("rand_count", n_out, n_in);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
